// File: rtl/fifo_sync_param_pkg.sv
// Shared definitions for fifo_sync_param: read-mode encoding and default
// almost-full/almost-empty thresholds.
package fifo_sync_param_pkg;

  typedef enum logic {
    MODE_STD  = 1'b0,
    MODE_FWFT = 1'b1
  } rd_mode_e;

  localparam int unsigned AE_THR_DEFAULT = 4;

  // Almost-full sits four entries below capacity; tiny FIFOs clamp to zero.
  function automatic int unsigned af_thr_default(input int unsigned depth);
    return (depth > 4) ? depth - 4 : 0;
  endfunction

endpackage

// File: rtl/fifo_sync_param_ram_2p.sv
// Two-port storage for fifo_sync_param: synchronous write, combinational read.
// A same-edge write and read of one address returns the old word.
module RAM_2p #(
  parameter int unsigned BUS_WIDTH  = 7,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  WE,
  input  logic [BUS_WIDTH-1:0]  ADDR_W,
  input  logic [DATA_WIDTH-1:0] DIN,
  input  logic [BUS_WIDTH-1:0]  ADDR_R,
  output logic [DATA_WIDTH-1:0] DOUT
);

  localparam int unsigned DEPTH = 1 << BUS_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (WE) r_mem[ADDR_W] <= DIN;
  end

  assign DOUT = r_mem[ADDR_R];

endmodule

// File: rtl/fifo_sync_param.sv
// Single-clock FIFO with guarded push/pop, standard or FWFT read mode,
// threshold flags, fill level, sticky error flags and synchronous clear.
module fifo_sync_param
  import fifo_sync_param_pkg::*;
#(
  parameter int unsigned BUS_WIDTH  = 7,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FWFT       = 0,
  parameter int unsigned AF_THR     = af_thr_default(1 << BUS_WIDTH),
  parameter int unsigned AE_THR     = AE_THR_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  WR,
  input  logic [DATA_WIDTH-1:0] DIN,
  input  logic                  RD,
  output logic [DATA_WIDTH-1:0] DOUT,
  output logic                  dout_valid,
  output logic                  full,
  output logic                  notEmpty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [BUS_WIDTH:0]    level,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned        DEPTH    = 1 << BUS_WIDTH;
  localparam rd_mode_e           MODE     = (FWFT != 0) ? MODE_FWFT : MODE_STD;
  localparam logic [BUS_WIDTH:0] LV_FULL  = (BUS_WIDTH+1)'(DEPTH);
  localparam logic [BUS_WIDTH:0] LV_AF    = (BUS_WIDTH+1)'(AF_THR);
  localparam logic [BUS_WIDTH:0] LV_AE    = (BUS_WIDTH+1)'(AE_THR);

  logic [BUS_WIDTH-1:0]  r_wrptr;
  logic [BUS_WIDTH-1:0]  r_rdptr;
  logic [BUS_WIDTH:0]    r_level;
  logic [DATA_WIDTH-1:0] r_dout;
  logic                  r_dout_valid;
  logic                  r_overflow;
  logic                  r_underflow;

  logic                  w_full;
  logic                  w_not_empty;
  logic                  w_rd_acc;
  logic                  w_wr_acc;
  logic [DATA_WIDTH-1:0] w_ram_dout;

  assign w_full      = (r_level == LV_FULL);
  assign w_not_empty = (r_level != '0);
  assign w_rd_acc    = RD & w_not_empty;
  // A pop frees the slot in the same edge, so a push on a full FIFO is taken.
  assign w_wr_acc    = WR & (~w_full | w_rd_acc);

  RAM_2p #(
    .BUS_WIDTH  (BUS_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .clk    (clk),
    .WE     (w_wr_acc & ~clr),
    .ADDR_W (r_wrptr),
    .DIN    (DIN),
    .ADDR_R (r_rdptr),
    .DOUT   (w_ram_dout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrptr      <= '0;
      r_rdptr      <= '0;
      r_level      <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_overflow   <= 1'b0;
      r_underflow  <= 1'b0;
    end else if (clr) begin
      r_wrptr      <= '0;
      r_rdptr      <= '0;
      r_level      <= '0;
      r_dout_valid <= 1'b0;
      r_overflow   <= 1'b0;
      r_underflow  <= 1'b0;
    end else begin
      if (w_wr_acc) r_wrptr <= r_wrptr + 1'b1;
      if (w_rd_acc) r_rdptr <= r_rdptr + 1'b1;
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      if (WR & ~w_wr_acc) r_overflow  <= 1'b1;
      if (RD & ~w_rd_acc) r_underflow <= 1'b1;
      if (w_rd_acc)       r_dout      <= w_ram_dout;
      r_dout_valid <= w_rd_acc & (MODE == MODE_STD);
    end
  end

  assign DOUT         = (MODE == MODE_FWFT) ? w_ram_dout  : r_dout;
  assign dout_valid   = (MODE == MODE_FWFT) ? w_not_empty : r_dout_valid;
  assign full         = w_full;
  assign notEmpty     = w_not_empty;
  assign almost_full  = (r_level >= LV_AF);
  assign almost_empty = (r_level <= LV_AE);
  assign level        = r_level;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Scoreboard bench for fifo_sync_param: an 8-deep standard-mode FIFO with
// custom thresholds, plus an 8-deep FWFT instance.
module tb_fifo_sync_param;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0;
  logic       WR = 1'b0;
  logic       RD = 1'b0;
  logic [7:0] DIN = '0;
  logic [7:0] DOUT;
  logic       dout_valid, full, notEmpty, almost_full, almost_empty, overflow, underflow;
  logic [3:0] level;

  logic       f_wr = 1'b0;
  logic       f_rd = 1'b0;
  logic [7:0] f_din = '0;
  logic [7:0] f_dout;
  logic       f_valid, f_full, f_not_empty, f_af, f_ae, f_ovf, f_unf;
  logic [3:0] f_level;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [7:0] sb_q[$];
  logic       m_ovf = 1'b0;
  logic       m_unf = 1'b0;
  logic [7:0] m_dout = '0;

  always #5 clk = ~clk;

  fifo_sync_param #(
    .BUS_WIDTH(3), .DATA_WIDTH(8), .FWFT(0), .AF_THR(6), .AE_THR(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .WR(WR), .DIN(DIN), .RD(RD),
    .DOUT(DOUT), .dout_valid(dout_valid), .full(full), .notEmpty(notEmpty),
    .almost_full(almost_full), .almost_empty(almost_empty), .level(level),
    .overflow(overflow), .underflow(underflow)
  );

  fifo_sync_param #(
    .BUS_WIDTH(3), .DATA_WIDTH(8), .FWFT(1)
  ) dut_fwft (
    .clk(clk), .rst_n(rst_n), .clr(1'b0), .WR(f_wr), .DIN(f_din), .RD(f_rd),
    .DOUT(f_dout), .dout_valid(f_valid), .full(f_full), .notEmpty(f_not_empty),
    .almost_full(f_af), .almost_empty(f_ae), .level(f_level),
    .overflow(f_ovf), .underflow(f_unf)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic check_status();
    int unsigned n;
    n = sb_q.size();
    check_eq("level",        32'(level),        32'(n));
    check_eq("full",         32'(full),         32'(n == 8));
    check_eq("notEmpty",     32'(notEmpty),     32'(n != 0));
    check_eq("almost_full",  32'(almost_full),  32'(n >= 6));
    check_eq("almost_empty", 32'(almost_empty), 32'(n <= 2));
    check_eq("overflow",     32'(overflow),     32'(m_ovf));
    check_eq("underflow",    32'(underflow),    32'(m_unf));
  endtask

  // One clock of stimulus; the model decides acceptance from pre-edge state.
  task automatic cycle(input logic wr, input logic [7:0] din, input logic rd, input logic c);
    logic rd_acc, wr_acc;
    logic [7:0] popped;
    WR = wr; DIN = din; RD = rd; clr = c;
    rd_acc = 1'b0;
    wr_acc = 1'b0;
    popped = '0;
    if (c) begin
      sb_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      rd_acc = rd && (sb_q.size() != 0);
      wr_acc = wr && ((sb_q.size() < 8) || rd_acc);
      if (rd_acc) begin
        popped = sb_q.pop_front();
        m_dout = popped;
      end
      if (wr_acc) sb_q.push_back(din);
      if (wr && !wr_acc) m_ovf = 1'b1;
      if (rd && !rd_acc) m_unf = 1'b1;
    end
    @(posedge clk);
    #1;
    WR = 1'b0; RD = 1'b0; clr = 1'b0;
    check_eq("dout_valid", 32'(dout_valid), 32'(rd_acc));
    check_eq("DOUT",       32'(DOUT),       32'(m_dout));
    check_status();
  endtask

  initial begin
    // Reset and idle
    #2;
    check_eq("rst_DOUT",     32'(DOUT), 32'h0);
    check_eq("rst_valid",    32'(dout_valid), 32'h0);
    check_status();
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    cycle(1'b0, 8'h00, 1'b0, 1'b0);

    // Fill, overflow, drain in order
    for (int i = 1; i <= 9; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);

    // Simultaneous push/pop on full across the pointer wrap
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) cycle(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'(8'h20 + i), 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Push/pop on empty: push only, underflow set
    cycle(1'b1, 8'hA5, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Level 5 with overflow set, then clear with a concurrent write
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) cycle(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b1, 8'hEE, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Random traffic
    for (int i = 0; i < 60; i++)
      cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 19) == 0));

    // Reset mid-operation drops everything
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    sb_q.delete();
    m_ovf = 1'b0; m_unf = 1'b0; m_dout = '0;
    check_eq("rst_mid_DOUT", 32'(DOUT), 32'h0);
    check_status();
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // FWFT: word visible the cycle after the push, before any pop
    check_eq("fwft_idle_valid", 32'(f_valid), 32'h0);
    f_wr = 1'b1; f_din = 8'h3C;
    @(posedge clk); #1;
    f_wr = 1'b0;
    check_eq("fwft_dout",  32'(f_dout),  32'h3C);
    check_eq("fwft_valid", 32'(f_valid), 32'h1);
    check_eq("fwft_level", 32'(f_level), 32'h1);
    f_rd = 1'b1;
    @(posedge clk); #1;
    f_rd = 1'b0;
    check_eq("fwft_valid_after_pop", 32'(f_valid), 32'h0);
    check_eq("fwft_level_after_pop", 32'(f_level), 32'h0);
    check_eq("fwft_underflow",       32'(f_unf),   32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
